// File: rtl/booth_mult_param.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock,
// fixed WIDTH/2+1 digit latency for both signed and unsigned operands.
module booth_mult_param #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] OUT,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [PW-1:0]  mc;    // multiplicand, pre-shifted by 2i for the current digit
  logic [PW-1:0]  acc;
  logic [PW-1:0]  pp;
  logic [PW-1:0]  sum;
  logic [WIDTH+2:0] mb;  // {2-bit extension, B, implicit bit -1}
  logic [CW-1:0]  cnt;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  // Upper extension bits beyond 2*WIDTH would be discarded modulo 2^(2*WIDTH),
  // so the multiplicand is held at 2*WIDTH bits only.
  always_comb begin
    pp = '0;
    case (mb[2:0])
      3'b001, 3'b010: pp = mc;
      3'b011:         pp = {mc[PW-2:0], 1'b0};
      3'b100:         pp = -{mc[PW-2:0], 1'b0};
      3'b101, 3'b110: pp = -mc;
      default:        pp = '0;
    endcase
  end

  assign sum = acc + pp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      OUT   <= '0;
      acc   <= '0;
      mc    <= '0;
      mb    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mc    <= signed_mode ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
          mb    <= {{2{signed_mode & B[WIDTH-1]}}, B, 1'b0};
          acc   <= '0;
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          acc <= sum;
          mc  <= {mc[PW-3:0], 2'b00};
          mb  <= {2'b00, mb[WIDTH+2:2]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            OUT   <= sum;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_param.sv
// Scoreboard bench for booth_mult_param: WIDTH=16 and WIDTH=8 instances,
// directed vectors, per-instance monitors pop expected products on handshake.
module tb_booth_mult_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv16, ir16, sm16, ov16, or16, bz16;
  logic [15:0] a16, b16;
  logic [31:0] out16;
  logic        iv8, ir8, sm8, ov8, or8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  booth_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .signed_mode(sm16), .OUT(out16), .out_valid(ov16), .out_ready(or16), .busy(bz16));

  booth_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .signed_mode(sm8), .OUT(out8), .out_valid(ov8), .out_ready(or8), .busy(bz8));

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic v16_prev = 1'b0;
  logic v8_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitors sample on the falling edge; stimulus moves 1 unit after the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (ov16 && !v16_prev) begin
      if (q16.size() == 0) report_fail("w16 unexpected out_valid");
      else check("w16 latency", 64'(cyc - q16[0].cyc), 64'd9);
    end
    if (ov16 && or16 && q16.size() > 0) begin
      e = q16.pop_front();
      check("w16 product", 64'(out16), e.prod);
    end
    v16_prev = ov16;
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov8 && !v8_prev) begin
      if (q8.size() == 0) report_fail("w8 unexpected out_valid");
      else check("w8 latency", 64'(cyc - q8[0].cyc), 64'd5);
    end
    if (ov8 && or8 && q8.size() > 0) begin
      e = q8.pop_front();
      check("w8 product", 64'(out8), e.prod);
    end
    v8_prev = ov8;
  end

  task automatic issue(input bit w8, input logic [15:0] a, input logic [15:0] b,
                       input bit sm, input logic [31:0] exp, input bit push);
    int t;
    t = 0;
    while (!(w8 ? ir8 : ir16) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(w8 ? ir8 : ir16)) begin
      report_fail("in_ready timeout");
      return;
    end
    if (w8) begin iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; end
    else    begin iv16 = 1'b1; a16 = a; b16 = b; sm16 = sm; end
    @(posedge clk); #1;
    iv8  = 1'b0;
    iv16 = 1'b0;
    if (push) begin
      if (w8) q8.push_back('{prod: 64'(exp), cyc: cyc});
      else    q16.push_back('{prod: 64'(exp), cyc: cyc});
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q16.size() != 0 || q8.size() != 0 || !ir16 || !ir8) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) report_fail("drain timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1;
    iv16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
    iv8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0; or8  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(ir16), 64'd1);
    check("reset out_valid", 64'(ov16), 64'd0);
    check("reset busy", 64'(bz16), 64'd0);
    check("reset OUT", 64'(out16), 64'd0);
    check("reset w8 in_ready", 64'(ir8), 64'd1);
    reset = 1'b0;

    // Unsigned / signed vectors, first one accepted on the edge right after reset
    issue(0, 16'd345, 16'd123, 0, 32'd42435, 1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("OUT retained in IDLE", 64'(out16), 64'd42435);
    issue(0, 16'd32245, 16'd32235, 0, 32'd1039417575, 1);
    issue(0, 16'hFFFE, 16'd3, 1, 32'hFFFF_FFFA, 1);
    issue(0, 16'h8000, 16'h8000, 1, 32'h4000_0000, 1);
    issue(0, 16'hFFFF, 16'hFFFF, 0, 32'hFFFE_0001, 1);
    issue(0, 16'hFFFF, 16'hFFFF, 1, 32'h0000_0001, 1);
    issue(0, 16'h7FFF, 16'h8000, 1, 32'hC000_8000, 1);
    issue(1, 16'h00FF, 16'h00FF, 0, 32'h0000_FE01, 1);
    issue(1, 16'h0080, 16'h007F, 1, 32'h0000_C080, 1);
    issue(1, 16'h0080, 16'h0080, 1, 32'h0000_4000, 1);
    drain();

    // Backpressure in DONE, with stray in_valid held through the release edge
    or16 = 1'b0;
    issue(0, 16'd32245, 16'd32235, 0, 32'd1039417575, 1);
    t = 0;
    while (!ov16 && t < 50) begin @(posedge clk); #1; t++; end
    if (!ov16) report_fail("bp out_valid timeout");
    for (int i = 0; i < 5; i++) begin
      iv16 = 1'b1; a16 = 16'd3; b16 = 16'd5;
      check("bp out_valid", 64'(ov16), 64'd1);
      check("bp OUT stable", 64'(out16), 64'd1039417575);
      check("bp in_ready", 64'(ir16), 64'd0);
      @(posedge clk); #1;
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    check("bp release in_ready", 64'(ir16), 64'd1);
    check("bp release busy", 64'(bz16), 64'd0);
    check("bp release OUT held", 64'(out16), 64'd1039417575);

    // Reset during the 4th BUSY cycle abandons the product
    issue(0, 16'd1234, 16'd5678, 0, 32'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midop busy", 64'(bz16), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midop reset OUT", 64'(out16), 64'd0);
    check("midop reset out_valid", 64'(ov16), 64'd0);
    check("midop reset in_ready", 64'(ir16), 64'd1);
    repeat (12) @(posedge clk);
    #1;
    issue(0, 16'd7, 16'd6, 0, 32'd42, 1);
    drain();

    // Operand/control churn while BUSY must not affect the result
    issue(0, 16'd789, 16'd987, 0, 32'd778743, 1);
    for (int i = 0; i < 7; i++) begin
      iv16 = i[0];
      a16  = ~a16;
      b16  = b16 ^ 16'h5A5A;
      sm16 = ~sm16;
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("w16 queue empty", 64'(q16.size()), 64'd0);
    check("w8 queue empty", 64'(q8.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult_param.md
BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values even, 4..32.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair present on A/B/signed_mode.
REQ-005 SHALL have port in_ready  output  1  block can accept operands this cycle.
REQ-006 SHALL have port A  input  WIDTH  multiplicand.
REQ-007 SHALL have port B  input  WIDTH  multiplier.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 SHALL have port OUT  output  2*WIDTH  product.
REQ-010 SHALL have port out_valid  output  1  OUT holds a completed product.
REQ-011 SHALL have port out_ready  input  1  consumer takes OUT this cycle.
REQ-012 SHALL have port busy  output  1  iteration in progress.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; busy 1 only in BUSY; out_valid 1 only in DONE.
REQ-015 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1: latch A, B, signed_mode; IDLE -> BUSY.
REQ-016 At accept, multiplier SHALL be extended to WIDTH+2 bits (sign-extended if signed_mode, else zero-extended) with implicit bit -1 = 0; multiplicand likewise extended to 2*WIDTH+2 bits.
REQ-017 BUSY SHALL retire one radix-4 Booth digit per cycle from overlapping triplets (b[2i+1], b[2i], b[2i-1]), adding 0, +-M, or +-2M shifted by 2i; arithmetic SHALL be modulo 2^(2*WIDTH).
REQ-018 Digit count N SHALL be WIDTH/2+1 for both modes (fixed latency; top digit is 0 in signed mode).
REQ-019 After the N-th BUSY edge, state SHALL be DONE with out_valid=1 and OUT = full 2*WIDTH-bit product; for WIDTH=16, out_valid first high 9 edges after the accept edge.
REQ-020 In DONE, OUT SHALL hold stable until out_ready=1 is sampled; that edge SHALL move DONE -> IDLE (in_ready high next cycle).
REQ-021 OUT SHALL retain the last product after leaving DONE until the next DONE entry overwrites it.
REQ-022 in_valid, A, B, signed_mode SHALL be ignored while in_ready=0; changes during BUSY SHALL not affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 in_valid=1 in the same cycle as the DONE -> IDLE transition SHALL not be accepted (in_ready is 0 that cycle).
REQ-025 Signed overflow-free: -2^(WIDTH-1) * -2^(WIDTH-1) SHALL yield +2^(2*WIDTH-2) exactly.

Reset
REQ-026 reset=1 sampled on an edge SHALL force IDLE, OUT=0, out_valid=0, busy=0, in_ready=1 on that edge, overriding all other inputs.
REQ-027 reset in BUSY or DONE SHALL abandon the operation with no later out_valid for it.
REQ-028 After reset deasserts, the first accept SHALL be possible on the next edge.

Verification
REQ-029 WIDTH=16, unsigned, A=345, B=123, out_ready=1 -> out_valid 9 edges after accept, OUT=42435; A=32245, B=32235 -> OUT=1039417575.
REQ-030 WIDTH=16: signed A=0xFFFE (-2), B=3 -> OUT=0xFFFFFFFA; signed A=B=0x8000 -> OUT=0x40000000; unsigned A=B=0xFFFF -> OUT=0xFFFE0001.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and OUT stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-032 Reset mid-operation: reset=1 at 4th BUSY cycle -> next edge OUT=0, out_valid=0, in_ready=1; no product emitted; new accept of 7*6 -> OUT=42.
REQ-033 Operand change during BUSY: A/B toggled every cycle after accept of 789*987 -> OUT=778743.
REQ-034 WIDTH=8 instance: unsigned 255*255 -> OUT=0xFE01 after 5 BUSY edges; signed 0x80*0x7F -> OUT=0xC080.
